// File: rtl/mode_selector_param.sv
// -----------------------------------------------------------------------------
// mode_selector_param
//
// Purpose:
//   Up/down mode selector for an appliance front panel. Two pre-debounced
//   buttons step a registered mode value between 0 and NUM_MODES-1. The mode
//   either saturates or wraps at the ends. Pressing both buttons together
//   reloads RESET_MODE. A held button auto-repeats: the first extra step comes
//   after REPEAT_DLY cycles, then one step every REPEAT_PER cycles.
//   Selection is frozen while the oven is cooking (start=1) or not idle
//   (idle=0). A button still held when the lock lifts never steps until it
//   has been released and pressed again.
//
// Parameters:
//   NUM_MODES  - number of selectable modes (2..256)
//   MODE_W     - width of the mode output
//   WRAP       - 0: saturate at the ends, 1: wrap around
//   RESET_MODE - mode loaded on reset and on a dual press (< NUM_MODES)
//   REPEAT_DLY - hold cycles before the first auto-repeat step (>= 1)
//   REPEAT_PER - cycles between later auto-repeat steps, 0 disables repeat
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   cook in progress, locks the selection
//   idle     in   oven idle, selection allowed only while high
//   btn_up   in   increment request (debounced, synchronous to clk)
//   btn_dwn  in   decrement request (debounced, synchronous to clk)
//   mode     out  current mode, registered
//   mode_chg out  one-cycle pulse whenever mode takes a new value
//   at_min   out  mode == 0, decoded from mode
//   at_max   out  mode == NUM_MODES-1, decoded from mode
//   locked   out  registered lock flag, high when start=1 or idle=0
// -----------------------------------------------------------------------------
module mode_selector_param #(
  parameter int NUM_MODES  = 4,
  parameter int MODE_W     = $clog2(NUM_MODES),
  parameter int WRAP       = 0,
  parameter int RESET_MODE = 0,
  parameter int REPEAT_DLY = 50,
  parameter int REPEAT_PER = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              idle,
  input  logic              btn_up,
  input  logic              btn_dwn,
  output logic [MODE_W-1:0] mode,
  output logic              mode_chg,
  output logic              at_min,
  output logic              at_max,
  output logic              locked
);

  typedef enum logic [1:0] {
    S_REL  = 2'd0,  // no button active, waiting for a press
    S_DLY  = 2'd1,  // single button held, counting the initial delay
    S_RPT  = 2'd2,  // single button held, auto-repeating
    S_WAIT = 2'd3   // buttons ignored until both are released
  } state_t;

  // The counter only ever holds load values (delay-1 or period-1), so it is
  // sized from the larger of the two; never narrower than one bit.
  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [MODE_W-1:0] MAX_MODE = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] RST_MODE = MODE_W'(RESET_MODE);
  localparam logic [CNT_W-1:0]  DLY_LOAD = CNT_W'((REPEAT_DLY > 0) ? REPEAT_DLY - 1 : 0);
  localparam logic [CNT_W-1:0]  PER_LOAD = CNT_W'((REPEAT_PER > 0) ? REPEAT_PER - 1 : 0);
  localparam bit                RPT_EN   = (REPEAT_PER > 0);

  // One step up, saturating or wrapping at the top. Any value at or above
  // MAX_MODE is treated as the top so a non-power-of-2 range never escapes.
  function automatic logic [MODE_W-1:0] step_up(input logic [MODE_W-1:0] m);
    if (m >= MAX_MODE) begin
      return (WRAP != 0) ? '0 : MAX_MODE;
    end
    return m + MODE_W'(1);
  endfunction

  // One step down, saturating or wrapping at the bottom.
  function automatic logic [MODE_W-1:0] step_dn(input logic [MODE_W-1:0] m);
    if (m == '0) begin
      return (WRAP != 0) ? MAX_MODE : '0;
    end
    if (m > MAX_MODE) begin
      return MAX_MODE;
    end
    return m - MODE_W'(1);
  endfunction

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              btn_up_p1;
  logic              btn_dwn_p1;
  logic              dir_up;

  logic              unlocked;
  logic              press_up;
  logic              press_dwn;
  logic              any_btn;
  logic              held_btn;
  logic              other_btn;
  logic              other_held;
  logic [MODE_W-1:0] mode_inc;
  logic [MODE_W-1:0] mode_dec;
  logic [MODE_W-1:0] mode_press;
  logic [MODE_W-1:0] mode_rpt;

  // ---- stage p0: decode current inputs against the previous button sample
  assign unlocked   = idle & ~start;
  assign press_up   = btn_up  & ~btn_up_p1;
  assign press_dwn  = btn_dwn & ~btn_dwn_p1;
  assign any_btn    = btn_up | btn_dwn;

  // A single press is only honoured when the opposite button is low; a press
  // while the other button is already held parks the FSM in S_WAIT.
  assign other_held = (press_up & btn_dwn) | (press_dwn & btn_up);

  assign held_btn   = dir_up ? btn_up  : btn_dwn;
  assign other_btn  = dir_up ? btn_dwn : btn_up;

  assign mode_inc   = step_up(mode);
  assign mode_dec   = step_dn(mode);
  assign mode_press = press_up ? mode_inc : mode_dec;
  assign mode_rpt   = dir_up   ? mode_inc : mode_dec;

  assign at_min     = (mode == '0);
  assign at_max     = (mode == MAX_MODE);

  // ---- stage p1: button history, lock flag, repeat FSM and mode register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode       <= RST_MODE;
      mode_chg   <= 1'b0;
      locked     <= 1'b1;
      state      <= S_REL;
      cnt        <= '0;
      // History of 1 hides a button held through reset release.
      btn_up_p1  <= 1'b1;
      btn_dwn_p1 <= 1'b1;
      dir_up     <= 1'b1;
    end else begin
      btn_up_p1  <= btn_up;
      btn_dwn_p1 <= btn_dwn;
      locked     <= ~unlocked;
      mode_chg   <= 1'b0;

      if (!unlocked) begin
        // Lock aborts any repeat without a step; a button still high must
        // be released before it can act again.
        cnt   <= '0;
        state <= any_btn ? S_WAIT : S_REL;
      end else begin
        case (state)
          S_REL: begin
            if (press_up && press_dwn) begin
              mode     <= RST_MODE;
              mode_chg <= (mode != RST_MODE);
              state    <= S_WAIT;
            end else if (other_held) begin
              state <= S_WAIT;
            end else if (press_up || press_dwn) begin
              mode     <= mode_press;
              mode_chg <= (mode_press != mode);
              dir_up   <= press_up;
              cnt      <= DLY_LOAD;
              state    <= S_DLY;
            end
          end

          S_DLY, S_RPT: begin
            if (!held_btn) begin
              cnt   <= '0;
              state <= S_REL;
            end else if (other_btn) begin
              cnt   <= '0;
              state <= S_WAIT;
            end else if (cnt != '0) begin
              cnt <= cnt - CNT_W'(1);
            end else if (RPT_EN) begin
              // With repeat disabled the FSM simply parks in S_DLY.
              mode     <= mode_rpt;
              mode_chg <= (mode_rpt != mode);
              cnt      <= PER_LOAD;
              state    <= S_RPT;
            end
          end

          S_WAIT: begin
            if (!any_btn) begin
              state <= S_REL;
            end
          end

          default: begin
            cnt   <= '0;
            state <= S_REL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mode_selector_param.sv
// -----------------------------------------------------------------------------
// tb_mode_selector_param
//
// Two instances share one stimulus stream:
//   dut_a : NUM_MODES=4, saturating, RESET_MODE=0, REPEAT_DLY=5, REPEAT_PER=3
//   dut_b : NUM_MODES=5, wrapping,   RESET_MODE=2, REPEAT_DLY=5, REPEAT_PER=0
// A behavioural model per instance describes the selector in terms of how long
// a single button has been held; a compare process checks every output on
// every falling edge, and directed literal expectations pin both the DUTs and
// the models at key points.
// -----------------------------------------------------------------------------
module tb_mode_selector_param;

  localparam int A_NM = 4, A_WRAP = 0, A_RM = 0, A_DLY = 5, A_PER = 3;
  localparam int B_NM = 5, B_WRAP = 1, B_RM = 2, B_DLY = 5, B_PER = 0;
  localparam int A_W = $clog2(A_NM);
  localparam int B_W = $clog2(B_NM);

  logic clk = 1'b0;
  logic rst, start, idle, btn_up, btn_dwn;

  logic [A_W-1:0] mode_a;
  logic           chg_a, min_a, max_a, lk_a;
  logic [B_W-1:0] mode_b;
  logic           chg_b, min_b, max_b, lk_b;

  mode_selector_param #(
    .NUM_MODES(A_NM), .MODE_W(A_W), .WRAP(A_WRAP), .RESET_MODE(A_RM),
    .REPEAT_DLY(A_DLY), .REPEAT_PER(A_PER)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start), .idle(idle),
    .btn_up(btn_up), .btn_dwn(btn_dwn),
    .mode(mode_a), .mode_chg(chg_a), .at_min(min_a), .at_max(max_a),
    .locked(lk_a)
  );

  mode_selector_param #(
    .NUM_MODES(B_NM), .MODE_W(B_W), .WRAP(B_WRAP), .RESET_MODE(B_RM),
    .REPEAT_DLY(B_DLY), .REPEAT_PER(B_PER)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start), .idle(idle),
    .btn_up(btn_up), .btn_dwn(btn_dwn),
    .mode(mode_b), .mode_chg(chg_b), .at_min(min_b), .at_max(max_b),
    .locked(lk_b)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  typedef struct packed {
    int mode;
    bit chg;
    bit locked;
    bit prev_up;
    bit prev_dn;
    bit blocked;   // buttons ignored until both are low
    int held;      // 0 none, 1 up held, 2 down held (single-button hold)
    int hold_len;  // edges since the press that started the hold
  } mdl_t;

  mdl_t m_a, m_b;
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic int next_mode(int m, int nm, int wrap, bit up);
    if (wrap != 0) return (m + (up ? 1 : nm - 1)) % nm;
    if (up) return (m + 1 > nm - 1) ? nm - 1 : m + 1;
    return (m - 1 < 0) ? 0 : m - 1;
  endfunction

  function automatic mdl_t mdl_reset(int rm);
    mdl_t r;
    r.mode = rm; r.chg = 1'b0; r.locked = 1'b1;
    r.prev_up = 1'b1; r.prev_dn = 1'b1;
    r.blocked = 1'b0; r.held = 0; r.hold_len = 0;
    return r;
  endfunction

  function automatic mdl_t mdl_step(mdl_t s, int nm, int wrap, int rm, int dly,
                                    int per, bit st, bit idl, bit up, bit dn);
    mdl_t n;
    bit   pu, pd, hb, ob;
    int   nx;
    n = s;
    n.chg = 1'b0;
    n.prev_up = up;
    n.prev_dn = dn;
    n.locked = !(idl && !st);
    pu = up && !s.prev_up;
    pd = dn && !s.prev_dn;
    if (n.locked) begin
      n.held = 0;
      n.blocked = up || dn;
      return n;
    end
    if (s.blocked) begin
      n.blocked = up || dn;
      return n;
    end
    if (s.held != 0) begin
      hb = (s.held == 1) ? up : dn;
      ob = (s.held == 1) ? dn : up;
      if (!hb) begin
        n.held = 0;
      end else if (ob) begin
        n.held = 0;
        n.blocked = 1'b1;
      end else begin
        n.hold_len = s.hold_len + 1;
        // Steps fall at hold time dly, dly+per, dly+2*per, ...
        if (per > 0 && n.hold_len >= dly && ((n.hold_len - dly) % per) == 0) begin
          nx = next_mode(s.mode, nm, wrap, s.held == 1);
          n.chg = (nx != s.mode);
          n.mode = nx;
        end
      end
      return n;
    end
    if (pu && pd) begin
      n.chg = (rm != s.mode);
      n.mode = rm;
      n.blocked = 1'b1;
    end else if ((pu && dn) || (pd && up)) begin
      n.blocked = 1'b1;
    end else if (pu || pd) begin
      nx = next_mode(s.mode, nm, wrap, pu);
      n.chg = (nx != s.mode);
      n.mode = nx;
      n.held = pu ? 1 : 2;
      n.hold_len = 0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a <= mdl_reset(A_RM);
      m_b <= mdl_reset(B_RM);
    end else begin
      m_a <= mdl_step(m_a, A_NM, A_WRAP, A_RM, A_DLY, A_PER, start, idle, btn_up, btn_dwn);
      m_b <= mdl_step(m_b, B_NM, B_WRAP, B_RM, B_DLY, B_PER, start, idle, btn_up, btn_dwn);
    end
  end

  // ---------------------------------------------------------------- checks
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic lit(input string name, input int dut_v, input int mdl_v, input int exp);
    chk({name, "_dut"}, dut_v, exp);
    chk({name, "_mdl"}, mdl_v, exp);
  endtask

  always @(negedge clk) begin
    chk("mode_a",   int'(mode_a), m_a.mode);
    chk("chg_a",    int'(chg_a),  int'(m_a.chg));
    chk("at_min_a", int'(min_a),  (m_a.mode == 0) ? 1 : 0);
    chk("at_max_a", int'(max_a),  (m_a.mode == A_NM - 1) ? 1 : 0);
    chk("locked_a", int'(lk_a),   int'(m_a.locked));
    chk("mode_b",   int'(mode_b), m_b.mode);
    chk("chg_b",    int'(chg_b),  int'(m_b.chg));
    chk("at_min_b", int'(min_b),  (m_b.mode == 0) ? 1 : 0);
    chk("at_max_b", int'(max_b),  (m_b.mode == B_NM - 1) ? 1 : 0);
    chk("locked_b", int'(lk_b),   int'(m_b.locked));
  end

  // ---------------------------------------------------------------- stimulus
  task automatic setin(input bit u, input bit d, input bit st, input bit id);
    @(negedge clk);
    btn_up = u; btn_dwn = d; start = st; idle = id;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  int exp_a1[9] = '{1, 2, 3, 3, 2, 1, 0, 0, 0};
  int exp_c1[9] = '{1, 1, 1, 0, 1, 1, 1, 0, 0};
  int exp_b1[9] = '{3, 4, 0, 1, 0, 4, 3, 2, 1};
  int hist_d[16], hist_m[16], hchg_d[16], hchg_m[16];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; idle = 1'b1; btn_up = 1'b0; btn_dwn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lit("rst_mode_a", int'(mode_a), m_a.mode, 0);
    lit("rst_mode_b", int'(mode_b), m_b.mode, 2);
    lit("rst_locked_a", int'(lk_a), int'(m_a.locked), 1);
    lit("rst_chg_a", int'(chg_a), int'(m_a.chg), 0);
    @(negedge clk);
    rst = 1'b0;
    edge1(); edge1();
    lit("unlock_a", int'(lk_a), int'(m_a.locked), 0);

    // single presses: 4 up then 5 down
    for (int i = 0; i < 9; i++) begin
      setin(i < 4, i >= 4, 1'b0, 1'b1);
      edge1();
      lit($sformatf("press%0d_mode_a", i), int'(mode_a), m_a.mode, exp_a1[i]);
      lit($sformatf("press%0d_chg_a", i),  int'(chg_a), int'(m_a.chg), exp_c1[i]);
      lit($sformatf("press%0d_mode_b", i), int'(mode_b), m_b.mode, exp_b1[i]);
      setin(1'b0, 1'b0, 1'b0, 1'b1);
      edge1();
    end

    // hold up for 15 edges from mode 0
    setin(1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 15; k++) begin
      edge1();
      hist_d[k] = int'(mode_a); hist_m[k] = m_a.mode;
      hchg_d[k] = int'(chg_a);  hchg_m[k] = int'(m_a.chg);
    end
    lit("rpt_e1",  hist_d[1],  hist_m[1],  1);
    lit("rpt_e5",  hist_d[5],  hist_m[5],  1);
    lit("rpt_e6",  hist_d[6],  hist_m[6],  2);
    lit("rpt_c6",  hchg_d[6],  hchg_m[6],  1);
    lit("rpt_e8",  hist_d[8],  hist_m[8],  2);
    lit("rpt_e9",  hist_d[9],  hist_m[9],  3);
    lit("rpt_c12", hchg_d[12], hchg_m[12], 0);
    lit("rpt_e15", hist_d[15], hist_m[15], 3);
    lit("rpt_b_per0", int'(mode_b), m_b.mode, 2);
    setin(1'b0, 1'b0, 1'b0, 1'b1);
    edge1();

    // idle low locks selection
    setin(1'b0, 1'b0, 1'b0, 1'b0);
    edge1();
    lit("idle_locked_a", int'(lk_a), int'(m_a.locked), 1);
    setin(1'b0, 1'b1, 1'b0, 1'b0);
    edge1();
    setin(1'b0, 1'b0, 1'b0, 1'b0);
    edge1();
    lit("idle_mode_a", int'(mode_a), m_a.mode, 3);
    lit("idle_mode_b", int'(mode_b), m_b.mode, 2);
    setin(1'b0, 1'b0, 1'b0, 1'b1);
    edge1();

    // start locks selection; button held across unlock does not step
    setin(1'b0, 1'b1, 1'b0, 1'b1);
    edge1();
    lit("dn_mode_a", int'(mode_a), m_a.mode, 2);
    setin(1'b0, 1'b0, 1'b0, 1'b1);
    edge1();
    setin(1'b0, 1'b0, 1'b1, 1'b1);
    edge1();
    lit("start_locked_a", int'(lk_a), int'(m_a.locked), 1);
    repeat (5) begin
      setin(1'b1, 1'b0, 1'b1, 1'b1);
      edge1();
      setin(1'b0, 1'b0, 1'b1, 1'b1);
      edge1();
    end
    lit("start_mode_a", int'(mode_a), m_a.mode, 2);
    lit("start_mode_b", int'(mode_b), m_b.mode, 1);
    setin(1'b1, 1'b0, 1'b1, 1'b1);
    edge1();
    setin(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (8) edge1();
    lit("held_unlock_mode_a", int'(mode_a), m_a.mode, 2);
    lit("held_unlock_locked_a", int'(lk_a), int'(m_a.locked), 0);
    setin(1'b0, 1'b0, 1'b0, 1'b1);
    edge1();
    setin(1'b1, 1'b0, 1'b0, 1'b1);
    edge1();
    lit("repress_mode_a", int'(mode_a), m_a.mode, 3);
    lit("repress_mode_b", int'(mode_b), m_b.mode, 2);
    setin(1'b0, 1'b0, 1'b0, 1'b1);
    edge1();

    // dual press from mode 2
    setin(1'b0, 1'b1, 1'b0, 1'b1);
    edge1();
    lit("pre_dual_mode_a", int'(mode_a), m_a.mode, 2);
    setin(1'b0, 1'b0, 1'b0, 1'b1);
    edge1();
    setin(1'b1, 1'b1, 1'b0, 1'b1);
    edge1();
    lit("dual_mode_a", int'(mode_a), m_a.mode, 0);
    lit("dual_chg_a", int'(chg_a), int'(m_a.chg), 1);
    lit("dual_mode_b", int'(mode_b), m_b.mode, 2);
    lit("dual_chg_b", int'(chg_b), int'(m_b.chg), 1);
    edge1();
    lit("dual_chg_a_next", int'(chg_a), int'(m_a.chg), 0);
    setin(1'b0, 1'b0, 1'b0, 1'b1);
    edge1();

    // second button pressed while first is held: both ignored
    setin(1'b1, 1'b0, 1'b0, 1'b1);
    edge1();
    lit("hold_up_mode_a", int'(mode_a), m_a.mode, 1);
    setin(1'b1, 1'b1, 1'b0, 1'b1);
    edge1();
    lit("cross_mode_a", int'(mode_a), m_a.mode, 1);
    setin(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (8) edge1();
    lit("cross_hold_mode_a", int'(mode_a), m_a.mode, 1);
    lit("cross_hold_mode_b", int'(mode_b), m_b.mode, 3);
    setin(1'b0, 1'b0, 1'b0, 1'b1);
    edge1();
    setin(1'b1, 1'b0, 1'b0, 1'b1);
    edge1();
    lit("cross_after_mode_a", int'(mode_a), m_a.mode, 2);
    setin(1'b0, 1'b0, 1'b0, 1'b1);
    edge1();

    // reset in the middle of an auto-repeat
    setin(1'b1, 1'b1, 1'b0, 1'b1);
    edge1();
    lit("dual2_mode_a", int'(mode_a), m_a.mode, 0);
    setin(1'b0, 1'b0, 1'b0, 1'b1);
    edge1();
    setin(1'b1, 1'b0, 1'b0, 1'b1);
    edge1();
    lit("mid_e1_mode_a", int'(mode_a), m_a.mode, 1);
    repeat (5) edge1();
    lit("mid_e6_mode_a", int'(mode_a), m_a.mode, 2);
    #2;
    rst = 1'b1;
    #1;
    lit("async_mode_a", int'(mode_a), m_a.mode, 0);
    lit("async_mode_b", int'(mode_b), m_b.mode, 2);
    lit("async_locked_a", int'(lk_a), int'(m_a.locked), 1);
    lit("async_chg_a", int'(chg_a), int'(m_a.chg), 0);
    @(negedge clk);
    edge1();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) edge1();
    lit("held_rst_mode_a", int'(mode_a), m_a.mode, 0);
    lit("held_rst_mode_b", int'(mode_b), m_b.mode, 2);
    setin(1'b0, 1'b0, 1'b0, 1'b1);
    edge1();
    setin(1'b1, 1'b0, 1'b0, 1'b1);
    edge1();
    lit("post_rst_mode_a", int'(mode_a), m_a.mode, 1);
    lit("post_rst_mode_b", int'(mode_b), m_b.mode, 3);
    setin(1'b0, 1'b0, 1'b0, 1'b1);
    edge1();
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mode_selector_param.md
MODE_SELECTOR_PARAM -- requirements
Module: mode_selector_param

Interface
REQ-001 SHALL provide parameter NUM_MODES, default 4: number of selectable modes, legal range 2..256.
REQ-002 SHALL provide parameter MODE_W, default $clog2(NUM_MODES): mode output width.
REQ-003 SHALL provide parameter WRAP, default 0: 0 = saturate at limits, 1 = wrap around.
REQ-004 SHALL provide parameter RESET_MODE, default 0: mode loaded on reset and on a dual press; must be < NUM_MODES.
REQ-005 SHALL provide parameter REPEAT_DLY, default 50: hold cycles before the first auto-repeat step.
REQ-006 SHALL provide parameter REPEAT_PER, default 10: cycles between subsequent auto-repeat steps; 0 disables auto-repeat.
REQ-007 SHALL have port: clk  input  1  system clock, rising edge.
REQ-008 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port: start  input  1  cook in progress; locks selection.
REQ-010 SHALL have port: idle  input  1  oven idle; selection is permitted only while high.
REQ-011 SHALL have port: btn_up  input  1  increment request; already debounced and synchronous to clk.
REQ-012 SHALL have port: btn_dwn  input  1  decrement request; already debounced and synchronous to clk.
REQ-013 SHALL have port: mode  output  MODE_W  current mode, registered.
REQ-014 SHALL have port: mode_chg  output  1  one-cycle pulse when mode changes value.
REQ-015 SHALL have port: at_min, at_max  output  1 each  mode == 0 / mode == NUM_MODES-1, combinational from mode.
REQ-016 SHALL have port: locked  output  1  registered; high when start=1 or idle=0.

Function
REQ-017 SHALL treat the unit as unlocked when idle=1 and start=0; locked SHALL reflect this with one cycle of latency.
REQ-018 SHALL register btn_up and btn_dwn each cycle; a press is a sample of 1 whose previous sample was 0.
REQ-019 SHALL, on an unlocked up press alone, step mode +1, visible after the same clock edge that samples the press.
REQ-020 SHALL, on an unlocked down press alone, step mode -1 with the same timing as REQ-019.
REQ-021 SHALL, with WRAP=0, hold mode at NUM_MODES-1 on up and at 0 on down, with no mode_chg pulse.
REQ-022 SHALL, with WRAP=1, step NUM_MODES-1 -> 0 on up and 0 -> NUM_MODES-1 on down.
REQ-023 SHALL ensure mode never exceeds NUM_MODES-1, including for non-power-of-2 NUM_MODES.
REQ-024 SHALL, when both buttons are pressed in the same cycle while unlocked, load RESET_MODE; mode_chg SHALL pulse only if the value differs.
REQ-025 SHALL, when one button is already held and the other is then pressed, ignore both until both are released.
REQ-026 SHALL implement the repeat FSM states: S_REL, S_DLY, S_RPT, S_WAIT.
REQ-027 SHALL move S_REL -> S_DLY on a single unlocked press, loading the counter with REPEAT_DLY-1.
REQ-028 SHALL, in S_DLY, step once and enter S_RPT (counter = REPEAT_PER-1) when the counter reaches 0 with the button still held.
REQ-029 SHALL, in S_RPT, step once each time the counter reaches 0, then reload it.
REQ-030 SHALL, with REPEAT_PER=0, stay in S_DLY with no repeat steps.
REQ-031 SHALL return S_DLY or S_RPT to S_REL in the cycle the held button is sampled 0.
REQ-032 SHALL, when locked, stop all steps and move to S_WAIT if any button is high, otherwise to S_REL.
REQ-033 SHALL leave S_WAIT only after both buttons are sampled 0; a held button SHALL never step after an unlock.
REQ-034 SHALL keep mode unchanged while locked; a lock change mid-repeat SHALL abort the repeat with no extra step.
REQ-035 SHALL size the counter to max(REPEAT_DLY, REPEAT_PER) bits via $clog2.

Reset
REQ-036 SHALL, while rst is asserted, asynchronously force: mode=RESET_MODE, mode_chg=0, locked=1, FSM=S_REL, counter=0, button history=1.
REQ-037 SHALL, with button history reset to 1, not count a button held through reset release as a press.

Verification
REQ-038 SHALL be verified with NUM_MODES=4, WRAP=0, idle=1: three up presses -> mode 1, 2, 3; fourth up -> mode stays 3, no mode_chg; five down presses -> 2, 1, 0, 0, 0.
REQ-039 SHALL be verified with NUM_MODES=5, WRAP=1: up from 4 -> 0 with a mode_chg pulse; down from 0 -> 4.
REQ-040 SHALL be verified with REPEAT_DLY=5, REPEAT_PER=3: hold up for 15 cycles from mode 0 -> steps at cycles 1, 6, 9, 12, 15 (saturating at 3); release -> S_REL.
REQ-041 SHALL be verified with start=1 and five up pulses -> mode unchanged; then start=0 while up is held -> no step until release and re-press.
REQ-042 SHALL be verified with mode=2 and btn_up/btn_dwn rising together -> mode=RESET_MODE(0) with mode_chg high for one cycle.
REQ-043 SHALL be verified with rst asserted mid-repeat -> mode=RESET_MODE immediately and no step from a button held through reset release.
